// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard/sequencing control slice.
// - md_op_e     : multiply/divide operation encoding carried with ID/EX instructions
// - ctrl_state_e: sequencer state (normal run, or one-cycle drain after a redirect)
// - MD_CNT_W    : width of the MD busy counter (covers cycle counts up to 63)
// - is_md_start : op launches a new multiply/divide
// - is_md_div   : op is a divide (selects the long latency)
package pipe_ctrl_pkg;

  localparam int unsigned MD_CNT_W = 6;

  typedef enum logic [3:0] {
    MD_NONE = 4'd0,
    MULT    = 4'd1,
    MULTU   = 4'd2,
    DIV     = 4'd3,
    DIVU    = 4'd4,
    MFHI    = 4'd5,
    MFLO    = 4'd6,
    MTHI    = 4'd7,
    MTLO    = 4'd8
  } md_op_e;

  typedef enum logic [0:0] {
    StRun   = 1'b0,
    StDrain = 1'b1
  } ctrl_state_e;

  function automatic logic is_md_start(input logic [3:0] op);
    return (op == MULT) || (op == MULTU) || (op == DIV) || (op == DIVU);
  endfunction

  function automatic logic is_md_div(input logic [3:0] op);
    return (op == DIV) || (op == DIVU);
  endfunction

endpackage

// File: rtl/hazard_ctrl_unit_md_busy_counter.sv
// Tracks how many cycles the multiply/divide unit still needs.
// Ports:
//   clk, reset : rising-edge clock, synchronous active-high reset
//   load       : start of a new MD operation; counter takes load_val
//   load_val   : latency of the operation being started
//   cancel     : abort the running operation; counter clears
//   busy       : counter non-zero
// Priority: reset/cancel > load > decrement. The decrement is unconditional
// (the MD unit keeps working through memory stalls).
module md_busy_counter
  import pipe_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic [MD_CNT_W-1:0] load_val,
  input  logic                cancel,
  output logic                busy
);

  logic [MD_CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (reset || cancel) begin
      cnt_d = '0;
    end else if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    cnt_q <= cnt_d;
  end

  assign busy = (cnt_q != '0);

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Central pipeline sequencer: produces stall/flush controls for the IF/ID,
// ID/EX and EX/MEM registers, tracks the multi-cycle MD unit, and sequences
// exception / ERET redirection. State is clocked on the rising edge so the
// outputs settle before the falling-edge pipeline registers sample them.
// Ports:
//   clk, reset         : clock, synchronous active-high reset
//   mem_stall          : memory not ready; freeze the whole pipeline
//   id_rs/rt_addr/used : source operands of the ID instruction
//   id_md_op           : MD op of the ID instruction (pipe_ctrl_pkg encoding)
//   ex_mem_r           : EX instruction is a load
//   ex_rd_addr         : destination of the EX instruction
//   ex_md_op           : MD op of the EX instruction
//   mem_exception      : MEM stage commits an exception
//   mem_eret           : MEM stage commits ERET
//   cp0_epc            : ERET return address
//   if/ifid/idex_stall : hold PC / IF/ID / ID/EX
//   ifid/idex/exmem_flush : clear the corresponding pipeline register
//   pc_redirect(_addr) : load PC with the redirect target
//   md_start/md_cancel : launch / abort an MD operation
//   md_busy            : MD operation still in flight
// Flushes are only ever raised with the matching stall low.
module hazard_ctrl_unit
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MUL_CYCLES = 4,  // min 1, max 63
  parameter int unsigned DIV_CYCLES = 32, // min 1, max 63
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0020
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_stall,
  input  logic [4:0]  id_rs_addr,
  input  logic [4:0]  id_rt_addr,
  input  logic        id_rs_used,
  input  logic        id_rt_used,
  input  logic [3:0]  id_md_op,
  input  logic        ex_mem_r,
  input  logic [4:0]  ex_rd_addr,
  input  logic [3:0]  ex_md_op,
  input  logic        mem_exception,
  input  logic        mem_eret,
  input  logic [31:0] cp0_epc,
  output logic        if_stall,
  output logic        ifid_stall,
  output logic        ifid_flush,
  output logic        idex_stall,
  output logic        idex_flush,
  output logic        exmem_flush,
  output logic        pc_redirect,
  output logic [31:0] pc_redirect_addr,
  output logic        md_start,
  output logic        md_cancel,
  output logic        md_busy
);

  ctrl_state_e state_q, state_d;

  logic                load_use;
  logic                md_hazard;
  logic [MD_CNT_W-1:0] md_load_val;

  // The load leaves EX next cycle, so this bubble lasts exactly one cycle.
  assign load_use = ex_mem_r && (ex_rd_addr != 5'd0) &&
                    ((id_rs_used && (id_rs_addr == ex_rd_addr)) ||
                     (id_rt_used && (id_rt_addr == ex_rd_addr)));

  // Any HI/LO access or new mul/div in ID must wait for the MD unit.
  assign md_hazard = md_busy && (id_md_op != MD_NONE);

  assign md_load_val = is_md_div(ex_md_op) ? MD_CNT_W'(DIV_CYCLES) : MD_CNT_W'(MUL_CYCLES);

  always_comb begin
    state_d          = state_q;
    if_stall         = 1'b0;
    ifid_stall       = 1'b0;
    idex_stall       = 1'b0;
    ifid_flush       = 1'b0;
    idex_flush       = 1'b0;
    exmem_flush      = 1'b0;
    pc_redirect      = 1'b0;
    pc_redirect_addr = 32'h0;
    md_start         = 1'b0;
    md_cancel        = 1'b0;

    if (reset) begin
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
      md_cancel   = 1'b1;
      state_d     = StRun;
    end else if (mem_stall) begin
      // Freeze everything; redirects wait until memory is ready.
      if_stall   = 1'b1;
      ifid_stall = 1'b1;
      idex_stall = 1'b1;
    end else if ((state_q == StRun) && (mem_exception || mem_eret)) begin
      pc_redirect      = 1'b1;
      pc_redirect_addr = mem_exception ? EXC_VECTOR : cp0_epc;
      ifid_flush       = 1'b1;
      idex_flush       = 1'b1;
      exmem_flush      = 1'b1;
      // Only an exception discards the in-flight MD result.
      md_cancel        = mem_exception;
      state_d          = StDrain;
    end else if (state_q == StDrain) begin
      // Kill the wrong-path instruction fetched alongside the redirect.
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
      state_d    = StRun;
    end else begin
      md_start = is_md_start(ex_md_op);
      if (md_hazard || load_use) begin
        if_stall   = 1'b1;
        ifid_stall = 1'b1;
        idex_flush = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    state_q <= state_d;
  end

  md_busy_counter u_md_busy_counter (
    .clk      (clk),
    .reset    (reset),
    .load     (md_start),
    .load_val (md_load_val),
    .cancel   (md_cancel),
    .busy     (md_busy)
  );

endmodule
